// File: rtl/be_pkg.sv
// ---------------------------------------------------------------------------
// be_pkg -- shared types and constants for the iterative RV32I back-end ALU.
//   RV32I_ALU_OP_t : ALU operation select (unlisted encodings act as NULL_alu)
//   be_alu_state_t : IDLE / SHIFT / DONE states of be_alu_iter
//   BE_XLEN        : datapath width (only 32 is supported)
//   BE_SHAMT_W     : shift-amount width, log2(BE_XLEN)
//   be_is_shift()  : true for SLL / SRL / SRA
// ---------------------------------------------------------------------------
package be_pkg;

  localparam int unsigned BE_XLEN    = 32;
  localparam int unsigned BE_SHAMT_W = 5;

  typedef enum logic [3:0] {
    NULL_alu = 4'd0,
    ADD_alu  = 4'd1,
    SUB_alu  = 4'd2,
    XOR_alu  = 4'd3,
    OR_alu   = 4'd4,
    AND_alu  = 4'd5,
    SLT_alu  = 4'd6,
    SLTU_alu = 4'd7,
    SLL_alu  = 4'd8,
    SRL_alu  = 4'd9,
    SRA_alu  = 4'd10
  } RV32I_ALU_OP_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } be_alu_state_t;

  function automatic logic be_is_shift(input RV32I_ALU_OP_t op);
    return (op == SLL_alu) || (op == SRL_alu) || (op == SRA_alu);
  endfunction

endpackage

// File: rtl/be_alu_comb.sv
// ---------------------------------------------------------------------------
// be_alu_comb -- purely combinational single-cycle RV32I ALU operations.
//   op_i     : operation select
//   a_i, b_i : operands
//   result_o : ADD/SUB/XOR/OR/AND/SLT/SLTU result; 0 for NULL_alu, shifts
//              (handled iteratively by the parent) and unlisted encodings
// ---------------------------------------------------------------------------
module be_alu_comb
  import be_pkg::*;
#(
  parameter int unsigned XLEN = BE_XLEN
) (
  input  RV32I_ALU_OP_t   op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ADD_alu:  result_o = a_i + b_i;
      SUB_alu:  result_o = a_i - b_i;
      XOR_alu:  result_o = a_i ^ b_i;
      OR_alu:   result_o = a_i | b_i;
      AND_alu:  result_o = a_i & b_i;
      SLT_alu:  result_o = ($signed(a_i) < $signed(b_i)) ? XLEN'(1) : '0;
      SLTU_alu: result_o = (a_i < b_i) ? XLEN'(1) : '0;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/be_alu_iter.sv
// ---------------------------------------------------------------------------
// be_alu_iter -- RV32I ALU with a one-bit-per-cycle iterative shifter.
//   clk, rst  : clock, asynchronous active-high reset
//   op_i      : operation select (captured on acceptance only)
//   a_i, b_i  : operands; b_i[SHAMT_W-1:0] is the shift amount
//   valid_i   : request valid      ready_o : idle, can accept a request
//   result_o  : registered result  valid_o : result valid (DONE state)
//   ready_i   : consumer takes the result
// Single-cycle ops and zero-length shifts complete with latency 1; a shift
// by N>0 walks the result register N times and completes with latency N+1.
// ---------------------------------------------------------------------------
module be_alu_iter
  import be_pkg::*;
#(
  parameter int unsigned XLEN    = BE_XLEN,
  parameter int unsigned SHAMT_W = BE_SHAMT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  RV32I_ALU_OP_t   op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  input  logic            ready_i
);

  be_alu_state_t        r_state;
  RV32I_ALU_OP_t        r_shop;
  logic [XLEN-1:0]      r_result;
  logic [SHAMT_W-1:0]   r_cnt;

  logic [XLEN-1:0]      w_comb_result;
  logic [SHAMT_W-1:0]   w_shamt;

  assign w_shamt = b_i[SHAMT_W-1:0];

  be_alu_comb #(
    .XLEN (XLEN)
  ) u_comb (
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .result_o (w_comb_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shop   <= NULL_alu;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            if (be_is_shift(op_i)) begin
              // Shift source is loaded as-is; a zero shift is already done.
              r_result <= a_i;
              if (w_shamt != '0) begin
                r_cnt   <= w_shamt;
                r_shop  <= op_i;
                r_state <= ST_SHIFT;
              end else begin
                r_state <= ST_DONE;
              end
            end else begin
              r_result <= w_comb_result;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          case (r_shop)
            SLL_alu: r_result <= {r_result[XLEN-2:0], 1'b0};
            SRL_alu: r_result <= {1'b0, r_result[XLEN-1:1]};
            default: r_result <= {r_result[XLEN-1], r_result[XLEN-1:1]};
          endcase
          r_cnt <= r_cnt - 1'b1;
          // Leave on the edge that takes the counter from 1 to 0.
          if (r_cnt == SHAMT_W'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o  = (r_state == ST_IDLE);
  assign valid_o  = (r_state == ST_DONE);
  assign result_o = r_result;

endmodule

// File: tb/tb_be_alu_iter.sv
// ---------------------------------------------------------------------------
// tb_be_alu_iter -- self-checking bench for be_alu_iter. Directed corner
// cases plus random operations compared against an arithmetic model of each
// operation's result and latency.
// ---------------------------------------------------------------------------
module tb_be_alu_iter;
  import be_pkg::*;

  logic          clk;
  logic          rst;
  RV32I_ALU_OP_t op_i;
  logic [31:0]   a_i;
  logic [31:0]   b_i;
  logic          valid_i;
  logic          ready_o;
  logic [31:0]   result_o;
  logic          valid_o;
  logic          ready_i;

  int unsigned n_checks;
  int unsigned n_fail;

  be_alu_iter #(
    .XLEN    (32),
    .SHAMT_W (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .result_o (result_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Result and latency (edges from acceptance to first valid_o sample).
  function automatic void model(input RV32I_ALU_OP_t op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output int unsigned lat);
    int unsigned sh;
    sh  = int'(b[4:0]);
    lat = 1;
    case (op)
      ADD_alu:  r = a + b;
      SUB_alu:  r = a - b;
      XOR_alu:  r = a ^ b;
      OR_alu:   r = a | b;
      AND_alu:  r = a & b;
      SLT_alu:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU_alu: r = (a < b) ? 32'd1 : 32'd0;
      SLL_alu:  begin r = a << sh; lat = sh + 1; end
      SRL_alu:  begin r = a >> sh; lat = sh + 1; end
      SRA_alu:  begin r = $signed(a) >>> sh; lat = sh + 1; end
      default:  r = 32'd0;
    endcase
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic do_op(input RV32I_ALU_OP_t op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold_valid, input int unsigned hold_cycles);
    logic [31:0] exp_res;
    int unsigned exp_lat;
    int unsigned lat;
    model(op, a, b, exp_res, exp_lat);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    chk("ready_before_accept", {31'd0, ready_o}, 32'd1);
    @(posedge clk); #1;
    if (!hold_valid) valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat <= 40) begin
      if (hold_valid) begin
        op_i = RV32I_ALU_OP_t'(4'($urandom_range(0, 15)));
        a_i  = $urandom;
        b_i  = $urandom;
      end
      ready_i = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    chk("latency", lat, exp_lat);
    chk("result", result_o, exp_res);
    for (int unsigned i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result_o, exp_res);
      chk("hold_valid", {31'd0, valid_o}, 32'd1);
      chk("hold_ready", {31'd0, ready_o}, 32'd0);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("valid_after_consume", {31'd0, valid_o}, 32'd0);
    chk("ready_after_consume", {31'd0, ready_o}, 32'd1);
  endtask

  initial begin
    int unsigned seen_valid;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    op_i     = NULL_alu;
    a_i      = '0;
    b_i      = '0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk); #1;

    // Directed corner cases.
    do_op(ADD_alu,  32'hFFFF_FFFF, 32'h1,  1'b0, 0);
    do_op(SRA_alu,  32'h8000_0000, 32'd31, 1'b0, 1);
    do_op(SRL_alu,  32'h8000_0000, 32'd31, 1'b0, 0);
    do_op(SLT_alu,  32'hFFFF_FFFF, 32'h1,  1'b0, 0);
    do_op(SLTU_alu, 32'hFFFF_FFFF, 32'h1,  1'b0, 0);
    do_op(SLL_alu,  32'h1,         32'h20, 1'b0, 5);
    do_op(SLL_alu,  32'h0000_00F1, 32'd7,  1'b1, 2);
    do_op(RV32I_ALU_OP_t'(4'd13), 32'h1234_5678, 32'h9, 1'b0, 0);

    // Reset in the 4th SHIFT cycle discards the operation.
    op_i = SLL_alu; a_i = 32'h1; b_i = 32'd10; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_mid_result", result_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen_valid = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_o) seen_valid++;
    end
    chk("no_valid_after_rst", seen_valid, 32'd0);
    do_op(ADD_alu, 32'd2, 32'd3, 1'b0, 0);

    // Random operations.
    for (int unsigned k = 0; k < 150; k++) begin
      do_op(RV32I_ALU_OP_t'(4'($urandom_range(0, 15))), $urandom, $urandom,
            1'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
